ws2812_pulse_decoder: RTL

- Single-stage, fully parametrised WS2812 bit decoder.
- Measures both the high and the low phase of each bit cell on an already-synchronised data line, then classifies each bit against configurable timing windows.
- Emits a bit strobe, a frame-reset strobe and a coded error strobe toward the shift register.
- Resynchronises on the reset gap after any timing violation. Replaces the split two-stage decode path.

---
 rtl/ws2812_pulse_decoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ws2812_pulse_decoder.sv
// WS2812 bit decoder: times the high and low phase of every bit cell on a synchronised line
// and emits bit, frame-reset and coded error strobes, relocking on a reset gap after errors.
module ws2812_pulse_decoder #(
  parameter int CNT_W         = 13,
  parameter int T0H_MIN       = 20,
  parameter int T0H_MAX       = 55,
  parameter int T1H_MIN       = 65,
  parameter int T1H_MAX       = 100,
  parameter int TL_MIN        = 30,
  parameter int TL_MAX        = 100,
  parameter int TRESET_CYCLES = 5000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_din,
  output logic       o_bit_value,
  output logic       o_bit_valid,
  output logic       o_treset,
  output logic       o_error,
  output logic [1:0] o_error_code,
  output logic       o_synced
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] T0H_MIN_C  = CNT_W'(T0H_MIN);
  localparam logic [CNT_W-1:0] T0H_MAX_C  = CNT_W'(T0H_MAX);
  localparam logic [CNT_W-1:0] T1H_MIN_C  = CNT_W'(T1H_MIN);
  localparam logic [CNT_W-1:0] T1H_MAX_C  = CNT_W'(T1H_MAX);
  localparam logic [CNT_W-1:0] T1H_OVER_C = CNT_W'(T1H_MAX + 1);
  localparam logic [CNT_W-1:0] TL_MIN_C   = CNT_W'(TL_MIN);
  localparam logic [CNT_W-1:0] TL_MAX_C   = CNT_W'(TL_MAX);
  localparam logic [CNT_W-1:0] TRESET_C   = CNT_W'(TRESET_CYCLES);

  localparam logic [1:0] ERR_HIGH_RANGE = 2'd1;
  localparam logic [1:0] ERR_AMBIGUOUS  = 2'd2;
  localparam logic [1:0] ERR_LOW_RANGE  = 2'd3;

  if (!(T0H_MIN <= T0H_MAX && T0H_MAX < T1H_MIN && T1H_MIN <= T1H_MAX &&
        TL_MIN <= TL_MAX && TL_MAX < TRESET_CYCLES &&
        T1H_MAX + 1 < (1 << CNT_W) && TRESET_CYCLES < (1 << CNT_W))) begin : g_bad_params
    $error("ws2812_pulse_decoder: illegal timing parameters");
  end

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             din_q, din_d;
  logic             pending_q, pending_d;
  logic             bit_value_q, bit_value_d;
  logic             bit_valid_q, bit_valid_d;
  logic             treset_q, treset_d;
  logic             error_q, error_d;
  logic [1:0]       error_code_q, error_code_d;
  logic             synced_q, synced_d;
  logic             rise, fall;

  always_comb begin
    state_d      = state_q;
    din_d        = i_din;
    pending_d    = pending_q;
    bit_value_d  = bit_value_q;
    bit_valid_d  = 1'b0;
    treset_d     = 1'b0;
    error_d      = 1'b0;
    error_code_d = error_code_q;
    rise         = i_din & ~din_q;
    fall         = ~i_din & din_q;
    cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    cnt_d        = (rise | fall) ? CNT_W'(1) : cnt_inc;

    case (state_q)
      // Hunting for a reset gap: only an unbroken low stretch counts.
      S_SYNC: begin
        cnt_d = i_din ? '0 : cnt_inc;
        if (!i_din && cnt_inc == TRESET_C) state_d = S_IDLE;
      end
      S_IDLE: begin
        cnt_d = cnt_q;
        if (rise) begin
          cnt_d   = CNT_W'(1);
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (fall) begin
          if (cnt_q < T0H_MIN_C || cnt_q > T1H_MAX_C) begin
            error_d      = 1'b1;
            error_code_d = ERR_HIGH_RANGE;
            state_d      = S_SYNC;
          end else if (cnt_q <= T0H_MAX_C) begin
            pending_d = 1'b0;
            state_d   = S_LOW;
          end else if (cnt_q < T1H_MIN_C) begin
            error_d      = 1'b1;
            error_code_d = ERR_AMBIGUOUS;
            state_d      = S_SYNC;
          end else begin
            pending_d = 1'b1;
            state_d   = S_LOW;
          end
        end else if (cnt_d == T1H_OVER_C) begin
          error_d      = 1'b1;
          error_code_d = ERR_HIGH_RANGE;
          state_d      = S_SYNC;
        end
      end
      // The pending bit is only released once the low phase proves the cell was legal.
      S_LOW: begin
        if (rise) begin
          if (cnt_q >= TL_MIN_C && cnt_q <= TL_MAX_C) begin
            bit_valid_d = 1'b1;
            bit_value_d = pending_q;
            state_d     = S_HIGH;
          end else begin
            error_d      = 1'b1;
            error_code_d = ERR_LOW_RANGE;
            state_d      = S_SYNC;
          end
        end else if (cnt_d == TRESET_C) begin
          bit_valid_d = 1'b1;
          bit_value_d = pending_q;
          treset_d    = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_SYNC;
    endcase

    synced_d = (state_d != S_SYNC);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_SYNC;
      cnt_q        <= '0;
      din_q        <= 1'b0;
      pending_q    <= 1'b0;
      bit_value_q  <= 1'b0;
      bit_valid_q  <= 1'b0;
      treset_q     <= 1'b0;
      error_q      <= 1'b0;
      error_code_q <= 2'd0;
      synced_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      din_q        <= din_d;
      pending_q    <= pending_d;
      bit_value_q  <= bit_value_d;
      bit_valid_q  <= bit_valid_d;
      treset_q     <= treset_d;
      error_q      <= error_d;
      error_code_q <= error_code_d;
      synced_q     <= synced_d;
    end
  end

  assign o_bit_value  = bit_value_q;
  assign o_bit_valid  = bit_valid_q;
  assign o_treset     = treset_q;
  assign o_error      = error_q;
  assign o_error_code = error_code_q;
  assign o_synced     = synced_q;

endmodule
